captura_operandos: RTL and testbench

Keypad operand-entry stage feeding the 12-bit adder. It consumes one-cycle key events from the keypad scanner/debouncer and accumulates decimal digits into two binary operands, `num1` and `num2`. On the "sum" key it issues a single-cycle `suma_btn` pulse. `num1`/`num2` are held stable long enough for the adder's IDLE→SUMA sequence to sample them.

---
 rtl/captura_operandos.sv | 166 ++++++++++++++++
 tb/tb_captura_operandos.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/captura_operandos.sv
// captura_operandos: keypad operand-entry stage for the 12-bit adder.
// Builds two decimal operands from one-cycle key events. On SUM it issues a
// one-cycle suma_btn pulse. The operands stay frozen through the pulse cycle
// and the cycle after it, so the adder can sample them.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ENTER_A   | accumulating digits into num1
// ENTER_B   | accumulating digits into num2
// SUM_PULSE | single cycle with suma_btn high, all keys ignored
// SHOW      | result displayed; a digit starts a new operation
module captura_operandos #(
    parameter int MAX_DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] num1,
    output logic [11:0] num2,
    output logic        suma_btn,
    output logic        operando_sel,
    output logic        mostrar_resultado,
    output logic [1:0]  digit_count
);

    localparam logic [1:0] ENTER_A   = 2'd0;
    localparam logic [1:0] ENTER_B   = 2'd1;
    localparam logic [1:0] SUM_PULSE = 2'd2;
    localparam logic [1:0] SHOW      = 2'd3;

    localparam logic [3:0] KEY_NEXT  = 4'hA;
    localparam logic [3:0] KEY_SUM   = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    logic [1:0]  state_q, state_d;
    logic [11:0] num1_q, num1_d;
    logic [11:0] num2_q, num2_d;
    logic        suma_q, suma_d;
    logic        sel_q, sel_d;
    logic        show_q, show_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        is_digit;
    logic        room;
    logic [11:0] digit_ext;

    assign is_digit  = (key_code <= 4'd9);
    assign room      = (cnt_q < MAX_CNT);
    assign digit_ext = 12'(key_code);

    // Next-state and output decode; everything defaults to hold, pulse defaults low.
    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        suma_d  = 1'b0;
        sel_d   = sel_q;
        show_d  = show_q;
        cnt_d   = cnt_q;

        case (state_q)
            ENTER_A: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (room) begin
                            num1_d = num1_q * 12'd10 + digit_ext;
                            cnt_d  = cnt_q + 2'd1;
                        end
                    end else if (key_code == KEY_NEXT) begin
                        if (cnt_q != 2'd0) begin
                            state_d = ENTER_B;
                            cnt_d   = 2'd0;
                            sel_d   = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        state_d = ENTER_A;
                        num1_d  = '0;
                        num2_d  = '0;
                        sel_d   = 1'b0;
                        show_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            ENTER_B: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (room) begin
                            num2_d = num2_q * 12'd10 + digit_ext;
                            cnt_d  = cnt_q + 2'd1;
                        end
                    end else if (key_code == KEY_SUM) begin
                        if (cnt_q != 2'd0) begin
                            state_d = SUM_PULSE;
                            suma_d  = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        state_d = ENTER_A;
                        num1_d  = '0;
                        num2_d  = '0;
                        sel_d   = 1'b0;
                        show_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            SUM_PULSE: begin
                // Keys are deliberately dropped here so the operands cannot move
                // while the adder is picking them up.
                state_d = SHOW;
                show_d  = 1'b1;
            end
            default: begin
                if (key_valid) begin
                    if (is_digit) begin
                        state_d = ENTER_A;
                        num1_d  = digit_ext;
                        num2_d  = '0;
                        sel_d   = 1'b0;
                        show_d  = 1'b0;
                        cnt_d   = 2'd1;
                    end else if (key_code == KEY_CLEAR) begin
                        state_d = ENTER_A;
                        num1_d  = '0;
                        num2_d  = '0;
                        sel_d   = 1'b0;
                        show_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    // State and output registers; synchronous reset wins over any key event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTER_A;
            num1_q  <= '0;
            num2_q  <= '0;
            suma_q  <= 1'b0;
            sel_q   <= 1'b0;
            show_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            suma_q  <= suma_d;
            sel_q   <= sel_d;
            show_q  <= show_d;
            cnt_q   <= cnt_d;
        end
    end

    assign num1              = num1_q;
    assign num2              = num2_q;
    assign suma_btn          = suma_q;
    assign operando_sel      = sel_q;
    assign mostrar_resultado = show_q;
    assign digit_count       = cnt_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed scenarios followed by random key
// traffic, all compared against a phase-level model of operand entry.
module tb_captura_operandos;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [11:0] num1, num2;
    logic        suma_btn, operando_sel, mostrar_resultado;
    logic [1:0]  digit_count;

    int checks = 0;
    int errors = 0;

    localparam int MAXD = 3;

    captura_operandos #(.MAX_DIGITS(MAXD)) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .num1(num1),
        .num2(num2),
        .suma_btn(suma_btn),
        .operando_sel(operando_sel),
        .mostrar_resultado(mostrar_resultado),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = entering A, 1 = entering B, 2 = pulse, 3 = show
    int phase = 0;
    int a_val = 0, a_n = 0;
    int b_val = 0, b_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        phase = 0; a_val = 0; a_n = 0; b_val = 0; b_n = 0;
    endtask

    task automatic model_update(input logic r, input logic kv, input logic [3:0] kc);
        int k;
        k = int'(kc);
        if (r) begin
            model_clear();
        end else if (phase == 2) begin
            phase = 3;
        end else if (kv) begin
            if (k == 12 && phase != 2) begin
                model_clear();
            end else if (phase == 0) begin
                if (k <= 9 && a_n < MAXD) begin a_val = a_val * 10 + k; a_n++; end
                else if (k == 10 && a_n > 0) phase = 1;
            end else if (phase == 1) begin
                if (k <= 9 && b_n < MAXD) begin b_val = b_val * 10 + k; b_n++; end
                else if (k == 11 && b_n > 0) phase = 2;
            end else if (phase == 3) begin
                if (k <= 9) begin
                    phase = 0; a_val = k; a_n = 1; b_val = 0; b_n = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("num1", 32'(num1), 32'(a_val));
        chk("num2", 32'(num2), 32'(b_val));
        chk("suma_btn", 32'(suma_btn), 32'(phase == 2));
        chk("operando_sel", 32'(operando_sel), 32'(phase != 0));
        chk("mostrar_resultado", 32'(mostrar_resultado), 32'(phase == 3));
        chk("digit_count", 32'(digit_count), 32'((phase == 0) ? a_n : b_n));
    endtask

    task automatic step(input logic r, input logic kv, input logic [3:0] kc);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_update(r, kv, kc);
        #1;
        compare_all();
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b0, 1'b1, kc);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        // Reset held with a live digit strobe
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'h5);
        chk("reset_num1", 32'(num1), 32'd0);
        idle();
        chk("after_reset_num1", 32'(num1), 32'd0);

        // Normal entry 123 + 45
        key(4'h1); key(4'h2); key(4'h3); key(4'hA); key(4'h4); key(4'h5);
        key(4'hB);
        chk("pulse_on", 32'(suma_btn), 32'd1);
        chk("pulse_num1", 32'(num1), 32'd123);
        chk("pulse_num2", 32'(num2), 32'd45);
        chk("adder_sum", 32'(num1) + 32'(num2), 32'd168);
        key(4'h7);  // strobed during SUM_PULSE, must be dropped
        chk("pulse_off", 32'(suma_btn), 32'd0);
        chk("show_on", 32'(mostrar_resultado), 32'd1);
        chk("hold_num1", 32'(num1), 32'd123);
        key(4'hD); key(4'hA); key(4'hB);
        // New operation from SHOW
        key(4'h7);
        chk("newop_num1", 32'(num1), 32'd7);
        chk("newop_num2", 32'(num2), 32'd0);
        chk("newop_cnt", 32'(digit_count), 32'd1);
        chk("newop_show", 32'(mostrar_resultado), 32'd0);

        // Limits
        key(4'hC);
        key(4'h9); key(4'h9); key(4'h9); key(4'h7);
        chk("max_num1", 32'(num1), 32'd999);
        chk("max_cnt", 32'(digit_count), 32'd3);
        key(4'hC);
        key(4'hA);
        chk("first_next_ignored", 32'(operando_sel), 32'd0);
        key(4'hB); key(4'hE);
        key(4'h0); key(4'hA);
        chk("zero_next_sel", 32'(operando_sel), 32'd1);
        key(4'hB); key(4'hF); key(4'hA);
        chk("empty_sum_no_pulse", 32'(suma_btn), 32'd0);
        key(4'h3); key(4'hB);
        // Reset during the pulse cycle
        step(1'b1, 1'b0, 4'h0);
        chk("rst_cuts_pulse", 32'(suma_btn), 32'd0);

        // Clear
        key(4'h5); key(4'hA); key(4'h6); key(4'hC);
        chk("clear_num1", 32'(num1), 32'd0);

        // Back-to-back strobes with random codes, sparse reset
        for (int i = 0; i < 3000; i++) begin
            logic r, kv;
            logic [3:0] kc;
            r  = ($urandom_range(0, 99) < 2);
            kv = ($urandom_range(0, 99) < 75);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: kc = 4'($urandom_range(0, 9));
                5, 6:          kc = 4'hA;
                7:             kc = 4'hB;
                8:             kc = ($urandom_range(0, 3) == 0) ? 4'hC : 4'hB;
                default:       kc = 4'($urandom_range(13, 15));
            endcase
            step(r, kv, kc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
